// File: rtl/operand_sweeper.sv
// Operand-pair generator for the 4-bit ALU/compare block. It issues either an exhaustive
// counter sweep or a maximal-length Galois LFSR sequence over a valid/ready handshake.
module operand_sweeper #(
  parameter int unsigned            WIDTH = 4,
  parameter logic [2*WIDTH-1:0]     SEED  = 8'hA5,
  parameter logic [2*WIDTH-1:0]     TAPS  = 8'hB8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               hold,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   in_1,
  output logic [WIDTH-1:0]   in_2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH:0]   count
);

  localparam int unsigned IW = 2 * WIDTH;
  localparam int unsigned CW = IW + 1;
  // An all-zero seed would lock the LFSR up, so substitute 1.
  localparam logic [IW-1:0] LfsrStart = (SEED == '0) ? IW'(1) : SEED;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [IW-1:0]   pair_q, pair_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   count_q, count_d;

  logic            fire;
  logic            last;
  logic            last_fire;
  logic            launch;
  logic [IW-1:0]   lfsr_next;

  assign fire      = valid_q & out_ready;
  assign lfsr_next = {1'b0, pair_q[IW-1:1]} ^ (pair_q[0] ? TAPS : '0);
  // The last LFSR pair is the one whose successor would repeat the start state.
  assign last      = mode_q ? (lfsr_next == LfsrStart) : (pair_q == '1);
  assign last_fire = fire & last;
  assign launch    = start & (state_q != StRun);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      pair_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pair_q  <= pair_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (last_fire) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    pair_d  = pair_q;
    count_d = count_q;
    valid_d = 1'b0;
    if (launch) begin
      mode_d  = mode;
      pair_d  = mode ? LfsrStart : '0;
      count_d = '0;
      valid_d = ~hold;
    end else if (state_q == StRun) begin
      if (fire) begin
        count_d = count_q + CW'(1);
      end
      // Keep the final pair on the outputs once the sweep completes.
      if (fire && !last) begin
        pair_d = mode_q ? lfsr_next : pair_q + IW'(1);
      end
      valid_d = ~last_fire & (~hold | (valid_q & ~out_ready));
    end
  end

  always_comb begin
    out_valid = valid_q;
    in_1      = pair_q[IW-1:WIDTH];
    in_2      = pair_q[WIDTH-1:0];
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    count     = count_q;
  end

endmodule

// File: doc/operand_sweeper.md
Name: operand_sweeper

Overview:
- Upstream stimulus stage that drives the in_1/in_2 operand pair of the 4-bit combinational ALU/compare block.
- Issues a complete sequence of operand pairs over a valid/ready handshake. Supports two orders: an exhaustive counter sweep, or a maximal-length LFSR sequence.
- Provides start/busy/done control and a count of accepted pairs, so the regression harness can run the arithmetic block over its full input space.

Parameters:
- WIDTH, 4, width of each operand. Sweep index is 2*WIDTH bits.
- SEED, 8'hA5, LFSR start state; 2*WIDTH bits.
- TAPS, 8'hB8, Galois LFSR feedback mask; 2*WIDTH bits. The default is maximal-length for 8 bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- mode  in  1  0 = exhaustive counter, 1 = LFSR; sampled with start.
- hold  in  1  pauses issue of new pairs.
- out_ready  in  1  downstream accepts the current pair.
- out_valid  out  1  in_1/in_2 hold a valid pair.
- in_1  out  WIDTH  operand A = state[2*WIDTH-1:WIDTH].
- in_2  out  WIDTH  operand B = state[WIDTH-1:0].
- busy  out  1  high in RUN.
- done  out  1  high in DONE, a level held until the next start.
- count  out  2*WIDTH+1  number of accepted pairs in the current or last sweep.

Behaviour:
- One clock domain; reset is synchronous and active-high. Port names are clk and reset.
- Reset values: state=IDLE, out_valid=0, in_1=0, in_2=0, busy=0, done=0, count=0, mode latch=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with start=1: go to RUN and latch mode. Load the pair register (counter mode 0; LFSR mode SEED, or 1 if SEED==0). Clear count and done.
  - First out_valid appears the cycle after start (latency 1), unless hold=1.
  - start in RUN is ignored.
- Handshake (fire = out_valid & out_ready):
  - On fire, count increments and the pair register advances.
  - in_1/in_2 are stable while out_valid=1 and out_ready=0. out_valid never drops without a fire.
  - Next-cycle out_valid = RUN & !last_fired & (!hold | (out_valid & !out_ready)).
  - hold only suppresses raising out_valid; it never retracts a pending pair. After hold deasserts, out_valid rises the following cycle with the already-advanced pair.
  - Back-to-back fires are allowed: one pair per cycle at out_ready=1, hold=0.
- Counter mode:
  - Index increments by 1, from 0 to 2^(2*WIDTH)-1.
  - Fire on the all-ones index is the last pair: total 256 for WIDTH=4.
- LFSR mode:
  - Galois right-shift step: lsb=s[0]; s=s>>1; if lsb then s^=TAPS.
  - The last pair is the one whose successor equals the start state: total 255 for the defaults.
  - State 0 is never issued.
- Last fire: next cycle out_valid=0, state=DONE, done=1, busy=0. in_1/in_2 retain the last pair and count retains its total.
- count width 2*WIDTH+1, so 256 is representable without wrap.
- reset mid-sweep: next cycle all outputs at reset values, regardless of the handshake in that cycle.
- Simultaneous reset and start: reset wins.

Test Plan:
- Counter sweep:
  - Stimulus: reset, start with mode=0, out_ready=1, hold=0.
  - Required: pairs in order (0,0),(0,1)…(0,F),(1,0) on the 17th…(F,F) on the 256th.
  - Then done=1 one cycle after the last fire, count=256, out_valid=0.
- LFSR sweep:
  - Stimulus: mode=1, SEED=A5.
  - Required: first pairs (A,5),(E,A),(7,5); 255 fires before done; count=255; no (0,0) pair.
  - Zero seed: SEED=00 with mode=1 gives first pair (0,1).
- Backpressure:
  - Stimulus: counter mode; drop out_ready for 3 cycles while pair (0,3) is valid.
  - Required: out_valid=1 and (0,3) held stable for all 3 cycles; (0,4) appears the cycle after the fire.
- Hold:
  - Stimulus: assert hold for 4 cycles with out_valid=1 and out_ready=0.
  - Required: the pending pair stays valid until fired.
  - After that fire: out_valid=0 while hold=1, and rises the cycle after hold=0 with the next pair.
- Reset mid-run:
  - Stimulus: reset asserted at pair (5,2) during a fire.
  - Required: next cycle out_valid=0, count=0, busy=0, done=0.
  - A new start then gives (0,0) again.
- Restart/ignore:
  - Stimulus: start pulsed during RUN.
  - Required: no effect.
  - A start in DONE clears done and count and restarts the sweep.
